// File: rtl/frame_scan_sequencer.sv
// frame_scan_sequencer
//
// Produces the column-major scan order (y fastest) for one full TFT frame and
// hands each (x, y) coordinate to the sprite/compositor path through a
// valid/ready handshake. A blanking window follows every frame. Every
// FRAME_DIV frames, a one-cycle update tick follows the blanking window so the
// ball sprites only move between frames and the picture never tears.
//
// Ports
//   clk, reset    clock and synchronous active-high reset
//   enable        level; high keeps frames running back to back
//   pix_ready     downstream accepts the presented pixel this cycle
//   pix_valid     x/y carry a pixel coordinate
//   x, y          current column / row (registered)
//   frame_start   pulse on the first cycle pixel (0,0) is presented
//   frame_end     pulse on the cycle the last pixel is accepted
//   update_tick   pulse telling the sprites to step their position
//   busy          high whenever a frame, blank or update is in progress
//   frame_count   completed frames, wraps at 16 bits
module frame_scan_sequencer #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int XW           = 9,
    parameter int YW           = 8,
    parameter int BLANK_CYCLES = 16,
    parameter int FRAME_DIV    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          pix_ready,
    output logic          pix_valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic          frame_end,
    output logic          update_tick,
    output logic          busy,
    output logic [15:0]   frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_BLANK,
        ST_UPDATE
    } state_t;

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(FRAME_DIV - 1);

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_end_c;
    logic            start_scan;

    // Next-state logic. start_scan gathers the three places a frame can begin
    // (leaving IDLE, BLANK or UPDATE) so the coordinate reset and the
    // frame_start pulse are produced in one spot.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        blank_cnt_d   = blank_cnt_q;
        div_cnt_d     = div_cnt_q;
        frame_count_d = frame_count_q;
        frame_start_d = 1'b0;
        frame_end_c   = 1'b0;
        start_scan    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    start_scan = 1'b1;
                end
            end

            ST_SCAN: begin
                if (pix_ready) begin
                    if (y_q != Y_LAST) begin
                        y_d = y_q + YW'(1);
                    end else if (x_q != X_LAST) begin
                        y_d = '0;
                        x_d = x_q + XW'(1);
                    end else begin
                        // Flagged in the accepting cycle itself so the pulse
                        // lines up with the final transfer.
                        frame_end_c   = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        blank_cnt_d   = '0;
                        state_d       = ST_BLANK;
                    end
                end
            end

            ST_BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    blank_cnt_d = '0;
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        state_d   = ST_UPDATE;
                    end else begin
                        div_cnt_d = div_cnt_q + DW'(1);
                        if (enable) begin
                            start_scan = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end

            ST_UPDATE: begin
                if (enable) begin
                    start_scan = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_scan) begin
            state_d       = ST_SCAN;
            x_d           = '0;
            y_d           = '0;
            frame_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            blank_cnt_q   <= '0;
            div_cnt_q     <= '0;
            frame_count_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            blank_cnt_q   <= blank_cnt_d;
            div_cnt_q     <= div_cnt_d;
            frame_count_q <= frame_count_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_valid   = (state_q == ST_SCAN);
    assign busy        = (state_q != ST_IDLE);
    assign update_tick = (state_q == ST_UPDATE);
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_c;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_count = frame_count_q;

endmodule
